// File: rtl/safe_lock_core.sv
// safe_lock_core: keypad lock controller with configurable code length,
// in-field code programming while open, and an optional failed-attempt lockout.
// Optional feature macro: SAFE_LOCKOUT_EN. When defined, repeated failures lead
// to a timed LOCKOUT state. When undefined, ERROR always returns to LOCKED.
//
// state       | meaning
// ------------+------------------------------------------------------------
// LOCKED  (0) | lock closed, collecting digits, '#' checks the code
// OPEN    (1) | lock released for OPEN_CYCLES, '*' starts programming
// PROGRAM (2) | lock released, collecting a new code, '#' stores it
// ERROR   (3) | wrong or partial entry, keys ignored for ERR_CYCLES
// LOCKOUT (4) | too many failures, keys ignored for LOCKOUT_CYCLES
`timescale 1ns/1ps

module safe_lock_core #(
  parameter int unsigned         DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = '0,
  parameter int unsigned         OPEN_CYCLES    = 50,
  parameter int unsigned         ERR_CYCLES     = 10,
  parameter int unsigned         MAX_FAILS      = 3,
  parameter int unsigned         LOCKOUT_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [11:0]           key,
  output logic                  lock,
  output logic [2:0]            state,
  output logic [4*DIGITS-1:0]   entry_code,
  output logic [3:0]            entry_count,
  output logic [3:0]            fail_count,
  output logic                  lockout
);

  localparam logic [2:0] ST_LOCKED  = 3'd0;
  localparam logic [2:0] ST_OPEN    = 3'd1;
  localparam logic [2:0] ST_PROGRAM = 3'd2;
  localparam logic [2:0] ST_ERROR   = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  // Timer is sized for the longest of the three timed states.
  localparam int unsigned MAX_OE  = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
  localparam int unsigned MAX_DUR = (MAX_OE > LOCKOUT_CYCLES) ? MAX_OE : LOCKOUT_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_DUR) + 1;

  // Loads are duration-1 so that the state is occupied for exactly the
  // duration: the exit happens on the edge where the counter reads zero.
  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ERR_LOAD  = TIMER_W'(ERR_CYCLES - 1);
`ifdef SAFE_LOCKOUT_EN
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]         FAIL_LIMIT   = 4'(MAX_FAILS);
`endif
  localparam logic [3:0]         FULL_COUNT   = 4'(DIGITS);

  if (DIGITS < 1 || DIGITS > 8 || MAX_FAILS < 1 || MAX_FAILS > 15) begin : g_param_check
    $error("safe_lock_core: DIGITS must be 1..8 and MAX_FAILS must be 1..15");
  end

  logic [2:0]            state_q;
  logic [2:0]            state_nxt;
  logic [TIMER_W-1:0]    timer_q;
  logic [TIMER_W-1:0]    timer_nxt;
  logic [4*DIGITS-1:0]   stored_code;
  logic [4*DIGITS-1:0]   stored_nxt;
  logic [4*DIGITS-1:0]   entry_code_nxt;
  logic [4*DIGITS-1:0]   entry_shifted;
  logic [3:0]            entry_count_nxt;
  logic [3:0]            fail_nxt;
  logic [3:0]            fail_inc;

  logic                  key_zero_q;
  logic                  key_onehot;
  logic                  press;
  logic                  press_digit;
  logic                  press_star;
  logic                  press_hash;
  logic [3:0]            digit_val;
  logic                  entry_full;
  logic                  code_match;
  logic                  timer_done;
  logic                  do_append;
  logic                  do_clear;

  // A press needs exactly one key now and a fully released keypad last cycle;
  // multi-hot samples keep key_zero_q low so they never act as a release.
  assign key_onehot  = (key != 12'd0) && ((key & (key - 12'd1)) == 12'd0);
  assign press       = key_onehot && key_zero_q;
  assign press_star  = press && key[10];
  assign press_hash  = press && key[11];
  assign press_digit = press && (key[9:0] != 10'd0);

  // Keypad history register: remembers whether the last sample was all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_zero_q <= 1'b1;
    end else begin
      key_zero_q <= (key == 12'd0);
    end
  end

  // Encode the single-hot digit key to its BCD value.
  always_comb begin
    digit_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) begin
        digit_val = 4'(i);
      end
    end
  end

  if (DIGITS == 1) begin : g_shift_one
    assign entry_shifted = digit_val;
  end else begin : g_shift_multi
    assign entry_shifted = {entry_code[4*DIGITS-5:0], digit_val};
  end

  assign entry_full = (entry_count == FULL_COUNT);
  assign code_match = (entry_code == stored_code);
  assign timer_done = (timer_q == '0);
  assign fail_inc   = (fail_count == 4'd15) ? fail_count : fail_count + 4'd1;

  // Next-state, timer, stored-code and fail-counter decisions.
  always_comb begin
    state_nxt  = state_q;
    timer_nxt  = timer_q;
    stored_nxt = stored_code;
    fail_nxt   = fail_count;
    do_append  = 1'b0;
    do_clear   = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (press_hash) begin
          if (entry_full && code_match) begin
            state_nxt = ST_OPEN;
            timer_nxt = OPEN_LOAD;
            fail_nxt  = 4'd0;
          end else begin
            state_nxt = ST_ERROR;
            timer_nxt = ERR_LOAD;
            fail_nxt  = fail_inc;
          end
        end else if (press_star) begin
          do_clear = 1'b1;
        end else if (press_digit && !entry_full) begin
          do_append = 1'b1;
        end
      end

      ST_OPEN: begin
        // Expiry wins over a '*' landing on the same edge.
        if (timer_done) begin
          state_nxt = ST_LOCKED;
        end else begin
          timer_nxt = timer_q - TIMER_W'(1);
          if (press_star) begin
            state_nxt = ST_PROGRAM;
          end
        end
      end

      ST_PROGRAM: begin
        if (press_star) begin
          state_nxt = ST_LOCKED;
        end else if (press_hash && entry_full) begin
          stored_nxt = entry_code;
          state_nxt  = ST_LOCKED;
        end else if (press_digit && !entry_full) begin
          do_append = 1'b1;
        end
      end

      ST_ERROR: begin
        if (timer_done) begin
`ifdef SAFE_LOCKOUT_EN
          if (fail_count >= FAIL_LIMIT) begin
            state_nxt = ST_LOCKOUT;
            timer_nxt = LOCKOUT_LOAD;
          end else begin
            state_nxt = ST_LOCKED;
          end
`else
          state_nxt = ST_LOCKED;
`endif
        end else begin
          timer_nxt = timer_q - TIMER_W'(1);
        end
      end

      ST_LOCKOUT: begin
`ifdef SAFE_LOCKOUT_EN
        if (timer_done) begin
          state_nxt = ST_LOCKED;
          fail_nxt  = 4'd0;
        end else begin
          timer_nxt = timer_q - TIMER_W'(1);
        end
`else
        state_nxt = ST_LOCKED;
`endif
      end

      default: begin
        state_nxt = ST_LOCKED;
      end
    endcase
  end

  // Entry register update: any state change wipes it, otherwise clear or shift.
  always_comb begin
    entry_code_nxt  = entry_code;
    entry_count_nxt = entry_count;
    if (state_nxt != state_q || do_clear) begin
      entry_code_nxt  = '0;
      entry_count_nxt = 4'd0;
    end else if (do_append) begin
      entry_code_nxt  = entry_shifted;
      entry_count_nxt = entry_count + 4'd1;
    end
  end

  // Core registers; reset abandons any state and restores the default code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOCKED;
      timer_q     <= '0;
      stored_code <= DEFAULT_CODE;
      entry_code  <= '0;
      entry_count <= 4'd0;
      fail_count  <= 4'd0;
    end else begin
      state_q     <= state_nxt;
      timer_q     <= timer_nxt;
      stored_code <= stored_nxt;
      entry_code  <= entry_code_nxt;
      entry_count <= entry_count_nxt;
      fail_count  <= fail_nxt;
    end
  end

  assign state = state_q;
  assign lock  = ~((state_q == ST_OPEN) || (state_q == ST_PROGRAM));
`ifdef SAFE_LOCKOUT_EN
  assign lockout = (state_q == ST_LOCKOUT);
`else
  assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_safe_lock_core.sv
// tb_safe_lock_core: table vectors, directed corner sequences and random
// keypad traffic, all compared against a queue-based behavioural model.
`timescale 1ns/1ps

module tb_safe_lock_core;

  localparam int DIGITS         = 4;
  localparam int OPEN_CYCLES    = 50;
  localparam int ERR_CYCLES     = 10;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 100;
  localparam logic [15:0] DEF_CODE = 16'h0000;
  localparam logic [11:0] K_STAR = 12'h400;
  localparam logic [11:0] K_HASH = 12'h800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] key = 12'd0;
  logic        lock;
  logic [2:0]  state;
  logic [15:0] entry_code;
  logic [3:0]  entry_count;
  logic [3:0]  fail_count;
  logic        lockout;

  int errors = 0;
  int checks = 0;

  safe_lock_core #(
    .DIGITS(DIGITS), .DEFAULT_CODE(DEF_CODE), .OPEN_CYCLES(OPEN_CYCLES),
    .ERR_CYCLES(ERR_CYCLES), .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .lock(lock), .state(state),
    .entry_code(entry_code), .entry_count(entry_count),
    .fail_count(fail_count), .lockout(lockout)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_state;          // 0 locked, 1 open, 2 program, 3 error, 4 lockout
  int m_q[$];           // digits entered, oldest first
  int m_code[DIGITS];   // stored code, most significant digit first
  int m_fail;
  int m_left;           // cycles still to spend in a timed state
  bit m_prev_zero;

  function automatic void model_reset();
    logic [15:0] d;
    d = DEF_CODE;
    m_state = 0;
    m_q.delete();
    for (int i = 0; i < DIGITS; i++) m_code[i] = int'(d[4*(DIGITS-1-i) +: 4]);
    m_fail = 0;
    m_left = 0;
    m_prev_zero = 1'b1;
  endfunction

  function automatic bit m_match();
    if (m_q.size() != DIGITS) return 1'b0;
    for (int i = 0; i < DIGITS; i++) if (m_q[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_entry();
    int v = 0;
    foreach (m_q[i]) v = (v << 4) | m_q[i];
    return v;
  endfunction

  function automatic void model_step(logic [11:0] k);
    bit pr;
    bit star = 1'b0;
    bit hash = 1'b0;
    int dig = -1;
    int nxt;
    pr = ($countones(k) == 1) && m_prev_zero;
    m_prev_zero = (k == 12'd0);
    if (pr) begin
      if (k[10]) star = 1'b1;
      else if (k[11]) hash = 1'b1;
      else for (int i = 0; i < 10; i++) if (k[i]) dig = i;
    end
    nxt = m_state;
    case (m_state)
      0: begin
        if (hash) begin
          if (m_match()) begin nxt = 1; m_left = OPEN_CYCLES; m_fail = 0; end
          else begin nxt = 3; m_left = ERR_CYCLES; if (m_fail < 15) m_fail++; end
        end else if (star) m_q.delete();
        else if (dig >= 0 && m_q.size() < DIGITS) m_q.push_back(dig);
      end
      1: begin
        m_left--;
        if (m_left == 0) nxt = 0;
        else if (star) nxt = 2;
      end
      2: begin
        if (star) nxt = 0;
        else if (hash && m_q.size() == DIGITS) begin
          for (int i = 0; i < DIGITS; i++) m_code[i] = m_q[i];
          nxt = 0;
        end else if (dig >= 0 && m_q.size() < DIGITS) m_q.push_back(dig);
      end
      3: begin
        m_left--;
        if (m_left == 0) begin
          nxt = 0;
`ifdef SAFE_LOCKOUT_EN
          if (m_fail >= MAX_FAILS) begin nxt = 4; m_left = LOCKOUT_CYCLES; end
`endif
        end
      end
      4: begin
        m_left--;
        if (m_left == 0) begin m_fail = 0; nxt = 0; end
      end
      default: nxt = 0;
    endcase
    if (nxt != m_state) m_q.delete();
    m_state = nxt;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model(string tag);
    chk({tag, " lock"}, 32'(lock), 32'((m_state == 1 || m_state == 2) ? 0 : 1));
    chk({tag, " state"}, 32'(state), 32'(m_state));
    chk({tag, " entry_code"}, 32'(entry_code), 32'(m_entry()));
    chk({tag, " entry_count"}, 32'(entry_count), 32'(m_q.size()));
    chk({tag, " fail_count"}, 32'(fail_count), 32'(m_fail));
    chk({tag, " lockout"}, 32'(lockout), 32'(m_state == 4));
  endtask

  function automatic logic [11:0] dkey(int d);
    logic [11:0] one;
    one = 12'd1;
    return one << d;
  endfunction

  task automatic tick(logic [11:0] k);
    key = k;
    @(posedge clk);
    model_step(k);
    #1;
    compare_model("model");
  endtask

  task automatic press_key(logic [11:0] k);
    tick(k);
    tick(12'd0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(12'd0);
  endtask

  task automatic enter_code(logic [15:0] c);
    for (int i = DIGITS - 1; i >= 0; i--) press_key(dkey(int'(c[4*i +: 4])));
    press_key(K_HASH);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, " lock"}, 32'(lock), 32'd1);
    chk({tag, " state"}, 32'(state), 32'd0);
    chk({tag, " entry_code"}, 32'(entry_code), 32'd0);
    chk({tag, " entry_count"}, 32'(entry_count), 32'd0);
    chk({tag, " fail_count"}, 32'(fail_count), 32'd0);
    chk({tag, " lockout"}, 32'(lockout), 32'd0);
  endtask

  typedef struct {
    logic [11:0] k;
    logic [2:0]  st;
    logic [15:0] code;
    logic [3:0]  cnt;
    logic        lk;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [11:0] last_k;
    logic [11:0] rk;
    int code_copy[DIGITS];

    vecs[0]  = '{12'h002, 3'd0, 16'h0001, 4'd1, 1'b1};
    vecs[1]  = '{12'h004, 3'd0, 16'h0012, 4'd2, 1'b1};
    vecs[2]  = '{12'h008, 3'd0, 16'h0123, 4'd3, 1'b1};
    vecs[3]  = '{12'h010, 3'd0, 16'h1234, 4'd4, 1'b1};
    vecs[4]  = '{12'h020, 3'd0, 16'h1234, 4'd4, 1'b1};
    vecs[5]  = '{K_STAR,  3'd0, 16'h0000, 4'd0, 1'b1};
    vecs[6]  = '{12'h003, 3'd0, 16'h0000, 4'd0, 1'b1};
    vecs[7]  = '{12'h001, 3'd0, 16'h0000, 4'd1, 1'b1};
    vecs[8]  = '{12'h001, 3'd0, 16'h0000, 4'd2, 1'b1};
    vecs[9]  = '{12'h001, 3'd0, 16'h0000, 4'd3, 1'b1};
    vecs[10] = '{12'h001, 3'd0, 16'h0000, 4'd4, 1'b1};
    vecs[11] = '{K_HASH,  3'd1, 16'h0000, 4'd0, 1'b0};
    vecs[12] = '{12'h020, 3'd1, 16'h0000, 4'd0, 1'b0};
    vecs[13] = '{K_HASH,  3'd1, 16'h0000, 4'd0, 1'b0};

    model_reset();
    rst_n = 1'b0;
    key = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: digit entry, overflow, clear, multi-hot, correct code opens.
    for (int i = 0; i < NV; i++) begin
      tick(vecs[i].k);
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d entry_code", i), 32'(entry_code), 32'(vecs[i].code));
      chk($sformatf("vec%0d entry_count", i), 32'(entry_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d lock", i), 32'(lock), 32'(vecs[i].lk));
      tick(12'd0);
    end
    // Six cycles of OPEN have elapsed since the '#' of vec11.
    idle(OPEN_CYCLES - 6);
    chk("open last cycle lock", 32'(lock), 32'd0);
    tick(12'd0);
    chk("open expired lock", 32'(lock), 32'd1);
    chk("open expired state", 32'(state), 32'd0);

    // Program a new code, reject the old one, accept the new one.
    enter_code(16'h0000);
    chk("prog open state", 32'(state), 32'd1);
    press_key(K_STAR);
    chk("prog enter state", 32'(state), 32'd2);
    chk("prog enter lock", 32'(lock), 32'd0);
    enter_code(16'h9876);
    chk("prog stored state", 32'(state), 32'd0);
    enter_code(16'h0000);
    chk("old code state", 32'(state), 32'd3);
    chk("old code fail_count", 32'(fail_count), 32'd1);
    idle(ERR_CYCLES);
    chk("error exit state", 32'(state), 32'd0);
    enter_code(16'h9876);
    chk("new code state", 32'(state), 32'd1);
    chk("new code fail_count", 32'(fail_count), 32'd0);
    idle(OPEN_CYCLES);

    // Three consecutive failures (one partial entry among them).
    enter_code(16'h1111);
    idle(ERR_CYCLES);
    press_key(dkey(3));
    press_key(K_HASH);
    idle(ERR_CYCLES);
    enter_code(16'h2222);
    chk("third fail fail_count", 32'(fail_count), 32'd3);
`ifdef SAFE_LOCKOUT_EN
    n = 0;
    while (!lockout && n < 50) begin tick(12'd0); n++; end
    chk("lockout entered", 32'(lockout), 32'd1);
    n = 1;
    while (lockout && n < 300) begin
      tick(($urandom_range(0, 1) == 0) ? 12'd0 : dkey($urandom_range(0, 11)));
      chk("lockout entry_count", 32'(entry_count), 32'd0);
      if (lockout) n++;
    end
    chk("lockout duration", 32'(n), 32'(LOCKOUT_CYCLES));
    chk("after lockout fail_count", 32'(fail_count), 32'd0);
    chk("after lockout state", 32'(state), 32'd0);
    tick(12'd0);
`else
    idle(ERR_CYCLES);
    chk("no lockout state", 32'(state), 32'd0);
    chk("no lockout lockout", 32'(lockout), 32'd0);
    chk("no lockout fail_count", 32'(fail_count), 32'd3);
`endif

    // Held key gives one digit; multi-hot neither enters nor releases.
    press_key(K_STAR);
    for (int i = 0; i < 20; i++) tick(dkey(5));
    tick(12'd0);
    chk("held key entry_count", 32'(entry_count), 32'd1);
    chk("held key entry_code", 32'(entry_code), 32'h5);
    press_key(12'h003);
    chk("multihot entry_count", 32'(entry_count), 32'd1);
    tick(dkey(5));
    tick(12'h003);
    tick(dkey(5));
    tick(12'd0);
    chk("multihot no release count", 32'(entry_count), 32'd2);
    chk("multihot no release code", 32'(entry_code), 32'h55);

    // Reset in PROGRAM with two digits entered loses the programmed code.
    press_key(K_STAR);
    enter_code(16'h9876);
    press_key(K_STAR);
    press_key(dkey(1));
    press_key(dkey(2));
    chk("pre-reset state", 32'(state), 32'd2);
    chk("pre-reset entry_count", 32'(entry_count), 32'd2);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_values("midop reset");
    @(negedge clk);
    rst_n = 1'b1;
    enter_code(16'h0000);
    chk("default code restored", 32'(state), 32'd1);
    idle(OPEN_CYCLES);

    // Random keypad traffic against the model.
    last_k = 12'd0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (i == 2000) begin
        @(negedge clk);
        rst_n = 1'b0;
        key = 12'd0;
        model_reset();
        #2;
        compare_model("random reset");
        @(negedge clk);
        rst_n = 1'b1;
        last_k = 12'd0;
      end else if (r < 96) begin
        if (r < 40) rk = 12'd0;
        else if (r < 70) rk = dkey($urandom_range(0, 9));
        else if (r < 78) rk = K_STAR;
        else if (r < 86) rk = K_HASH;
        else if (r < 90) rk = dkey($urandom_range(0, 11)) | dkey($urandom_range(0, 11));
        else rk = last_k;
        tick(rk);
        last_k = rk;
      end else begin
        tick(12'd0);
        for (int j = 0; j < DIGITS; j++) code_copy[j] = m_code[j];
        for (int j = 0; j < DIGITS; j++) press_key(dkey(code_copy[j]));
        press_key(K_HASH);
        last_k = 12'd0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/safe_lock_core.md
# safe_lock_core

Parametrised lock core for the digital safe, the successor to the fixed four-digit top level. It folds keypad decode, press-edge detection, the digit entry register, stored-code compare, and open/error timers into one block behind a single FSM. It adds a configurable code length, in-field re-programming of the code while open, and an optional failed-attempt lockout. The seven-segment drivers attach outside it to `entry_code` and `state`.

## Interface
- `DIGITS`, default 4: code length in BCD digits, 1..8.
- `DEFAULT_CODE`, default 0: code loaded at reset, `4*DIGITS` bits, one BCD digit per nibble.
- `OPEN_CYCLES`, default 50: cycles the lock stays released.
- `ERR_CYCLES`, default 10: cycles spent in ERROR.
- `MAX_FAILS`, default 3: consecutive failures that trigger lockout, 1..15.
- `LOCKOUT_CYCLES`, default 100: lockout duration in cycles.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `key` in 12: raw keypad. `[9:0]` are digits 0-9, `[10]` is `*` (clear/program), `[11]` is `#` (enter).
- `lock` out 1: 1 means locked.
- `state` out 3: FSM state code for the display mux.
- `entry_code` out `4*DIGITS`: digits entered so far, newest digit in `[3:0]`.
- `entry_count` out 4: number of digits entered, 0..`DIGITS`.
- `fail_count` out 4: consecutive failures.
- `lockout` out 1: 1 while in LOCKOUT.

## Operation
- **Press detection**
  - A press is a single-hot `key` sampled on an edge where the previous sample was all-zero.
  - Multi-hot or held keys are ignored. A multi-hot sample does not count as a release.
- **Entry register**
  - A digit press with `entry_count < DIGITS` does `entry_code <= {entry_code[4*DIGITS-5:0], digit}` and increments `entry_count`.
  - Digit presses when `entry_count == DIGITS` are ignored.
  - The entry register is cleared on every state change.
- **State codes**
  - LOCKED=0, OPEN=1, PROGRAM=2, ERROR=3, LOCKOUT=4.
- **LOCKED** (reset state, `lock`=1)
  - Digits fill the entry register. `*` clears it.
  - `#` with a full entry matching the stored code goes to OPEN and sets `fail_count` to 0.
  - `#` with a full entry that does not match goes to ERROR.
  - `#` with a partial entry (including empty) goes to ERROR.
- **OPEN** (`lock`=0)
  - The timer loads `OPEN_CYCLES`. On expiry the FSM goes to LOCKED.
  - `*` goes to PROGRAM. Digits and `#` are ignored.
- **PROGRAM** (`lock`=0, no timeout)
  - Digits fill the entry register.
  - `#` with a full entry loads the stored code and goes to LOCKED.
  - `#` with a partial entry is ignored.
  - `*` abandons programming and goes to LOCKED, keeping the old code.
- **ERROR** (`lock`=1)
  - On entry, `fail_count` increments, saturating at 15.
  - All keys are ignored for `ERR_CYCLES` cycles.
  - On exit the FSM goes to LOCKOUT if lockout is enabled and `fail_count >= MAX_FAILS`, otherwise to LOCKED.
- **LOCKOUT** (`lock`=1, `lockout`=1)
  - All keys are ignored for `LOCKOUT_CYCLES` cycles.
  - On exit `fail_count` is set to 0 and the FSM goes to LOCKED.
- **Compare**
  - Full-width equality of `entry_code` against the stored code, evaluated combinationally.
- **Reset values**
  - `lock`=1, `state`=0, `entry_code`=0, `entry_count`=0, `fail_count`=0, `lockout`=0.
  - Stored code = `DEFAULT_CODE`. The press-history register reads as released.
- **Reset mid-operation**
  - Any state is abandoned immediately. A code being programmed is lost.

## Timing
- A press sampled at edge N updates `entry_code`, `state` and `lock` after edge N. Decode-to-register latency is 1 cycle.
- State durations:
  - OPEN lasts exactly `OPEN_CYCLES` cycles, so `lock` is 0 for `OPEN_CYCLES` cycles.
  - ERROR lasts exactly `ERR_CYCLES` cycles.
  - LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles.
- The timer counts down. Its width is `$clog2` of the largest duration parameter plus 1.
- A key held across a state change does not re-trigger; it must be released first.
- Presses on the edge where a timer expires are ignored.

## Configuration
- `SAFE_LOCKOUT_EN` defined:
  - The LOCKOUT state and the `MAX_FAILS` check are present.
- `SAFE_LOCKOUT_EN` undefined:
  - ERROR always returns to LOCKED.
  - `lockout` is tied to 0.
  - `fail_count` still counts and saturates.

## Test plan
- Reset with `DIGITS=4`, `DEFAULT_CODE=0`, then press 0,0,0,0,`#` → `lock`=0 one cycle after `#`, held 50 cycles, then `lock`=1 and `state`=0.
- Press 1,2,3,4,5 → `entry_code`=16'h1234, `entry_count`=4; the fifth digit is ignored. Then `*` → `entry_code`=0, `entry_count`=0.
- Open, press `*`, press 9,8,7,6,`#` → `state`=0. Then 0,0,0,0,`#` → ERROR. Then 9,8,7,6,`#` → OPEN.
- With `SAFE_LOCKOUT_EN` defined: three wrong entries → `fail_count`=3 and `lockout`=1 for 100 cycles. Presses during lockout cause no change. Afterwards `fail_count`=0.
- Hold key 5 for 20 cycles → one digit entered. Press `key`=12'h003 (multi-hot) → no entry.
- Assert `rst_n`=0 while in PROGRAM with 2 digits entered → all outputs return to reset values and the stored code reverts to `DEFAULT_CODE`.
